// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
//   Shared types and helpers for the FIFO write arbiter.
//   state_t : arbiter FSM state encoding
//   idw_f   : width of the source-ID field, max(1, clog2(nreq))
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int idw_f(input int nreq);
    int w;
    w = $clog2(nreq);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
//   Round-robin selector: returns the first set bit of req, scanning
//   upward from start and wrapping at NREQ.
// Ports:
//   req   in  NREQ  request vector
//   start in  IDW   index with highest priority
//   idx   out IDW   selected index (0 when none found)
//   found out 1     at least one request set
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the candidate
  // closest to start is the last one written and therefore wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((32'(start) + 32'(k)) % 32'(NREQ));
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Arbitrates NREQ beat streams into one FIFO write port. A requester is
//   granted round-robin and may deliver up to MAX_BURST beats before the
//   grant is released; each release costs one idle cycle.
// Optional feature: define FIFO_WR_ARB_STATS_EN to build the per-requester
//   saturating accepted-beat counters; otherwise stat_cnt is tied to 0.
// Ports:
//   clk        in   1            system clock
//   rst        in   1            synchronous reset, active low
//   req_valid  in   NREQ         per-requester beat valid
//   req_data   in   NREQ*WIDTH   payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ         per-requester beat accept (combinational)
//   wr_en      out  1            FIFO write strobe, one cycle after accept
//   din        out  WIDTH+IDW    {source id, payload}
//   prog_full  in   1            FIFO backpressure
//   stat_cnt   out  NREQ*32      accepted-beat counters, requester i at [i*32 +: 32]
//
// state | meaning
// IDLE  | no grant; pick next requester from rr_ptr
// BURST | requester 'grant' owns the FIFO write port
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = idw_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr_en,
  output logic [WIDTH+IDW-1:0]  din,
  input  logic                  prog_full,
  output logic [NREQ*32-1:0]    stat_cnt
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   grant, grant_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]    burst_cnt, burst_cnt_nxt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             gnt_valid;
  logic             accept;
  logic             last_beat;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) gnt_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign gnt_valid = req_valid[grant];
  assign accept    = (state == BURST) && !prog_full && gnt_valid;
  assign last_beat = (burst_cnt == CW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if ((state == BURST) && !prog_full) req_ready[grant] = 1'b1;
  end

  // Under prog_full the whole BURST branch is frozen: no accept, no count
  // change, and a low valid does not release the grant.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt     = BURST;
          grant_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (!prog_full) begin
          if (accept) burst_cnt_nxt = burst_cnt + 1'b1;
          if ((accept && last_beat) || !gnt_valid) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Reset wins over an accept in the same cycle, so that beat is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en <= 1'b0;
      din   <= '0;
    end else begin
      wr_en <= accept;
      if (accept) din <= {grant, gnt_data};
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] stat_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (accept && (stat_q[grant] != 32'hFFFF_FFFF)) begin
      stat_q[grant] <= stat_q[grant] + 32'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_cnt[g*32 +: 32] = stat_q[g];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
//   Directed bench for fifo_wr_arb. u_dut uses MAX_BURST=4, u_dut_b uses
//   MAX_BURST=2 for the fairness sequence. Inputs change 1 time unit after
//   the rising edge; written FIFO words are logged on the falling edge.
module tb_fifo_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   req_valid;
  logic         prog_full;
  logic [7:0]   lane [4];
  logic [31:0]  req_data;
  logic [3:0]   req_ready;
  logic         wr_en;
  logic [9:0]   din;
  logic [127:0] stat_cnt;

  logic [3:0]   vb;
  logic [31:0]  data_b;
  logic [3:0]   ready_b;
  logic         wr_en_b;
  logic [9:0]   din_b;
  logic [127:0] stat_b;

  assign req_data = {lane[3], lane[2], lane[1], lane[0]};
  assign data_b   = 32'hB3B2_B1B0;

  fifo_wr_arb #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .din       (din),
    .prog_full (prog_full),
    .stat_cnt  (stat_cnt)
  );

  fifo_wr_arb #(.WIDTH(8), .NREQ(4), .MAX_BURST(2)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vb),
    .req_data  (data_b),
    .req_ready (ready_b),
    .wr_en     (wr_en_b),
    .din       (din_b),
    .prog_full (1'b0),
    .stat_cnt  (stat_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int cyc      = 0;

  logic [9:0] q_a [$];
  int         t_a [$];
  logic [9:0] q_b [$];
  int         t_b [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      q_a.push_back(din);
      t_a.push_back(cyc);
    end
    if (wr_en_b) begin
      q_b.push_back(din_b);
      t_b.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: the handshake seen just before the edge advances that
  // requester's payload, modelling a source that steps on accept.
  task automatic step();
    logic [3:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) lane[i] = lane[i] + 8'd1;
    end
    if (acc != 4'b0) n_acc++;
  endtask

  task automatic run_until(input int beats);
    int guard;
    guard = 0;
    while (n_acc < beats && guard < 60) begin
      step();
      guard++;
    end
  endtask

  logic [9:0] exp_fair [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_fair = '{10'h0B0, 10'h0B0, 10'h1B1, 10'h1B1, 10'h2B2,
                 10'h2B2, 10'h3B3, 10'h3B3, 10'h0B0, 10'h0B0};
    for (int i = 0; i < 4; i++) lane[i] = 8'(16 * (i + 1));
    rst       = 1'b0;
    req_valid = 4'b0;
    prog_full = 1'b0;
    vb        = 4'b0;
    step();
    step();
    check_val("rst_wr_en", 64'(wr_en), 64'd0);
    check_val("rst_din", 64'(din), 64'd0);
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_stat", 64'(stat_cnt[63:0] | stat_cnt[127:64]), 64'd0);

    // single requester, two full bursts
    rst       = 1'b1;
    req_valid = 4'b0010;
    #1;
    check_val("post_rst_ready", 64'(req_ready), 64'd0);
    n_acc = 0;
    run_until(8);
    req_valid = 4'b0;
    repeat (3) step();
    check_val("t1_beats", 64'(q_a.size()), 64'd8);
    for (int k = 0; k < 8; k++) check_val("t1_din", 64'(q_a[k]), 64'(10'h120 + 10'(k)));
    check_val("t1_gap_in_burst", 64'(t_a[3] - t_a[0]), 64'd3);
    check_val("t1_bubble", 64'(t_a[4] - t_a[3]), 64'd2);
    check_val("t1_gap_burst2", 64'(t_a[7] - t_a[4]), 64'd3);

    // fairness on the MAX_BURST=2 instance
    vb = 4'hF;
    begin
      int guard;
      guard = 0;
      while (q_b.size() < 10 && guard < 60) begin
        step();
        guard++;
      end
    end
    vb = 4'b0;
    repeat (3) step();
    check_val("fair_beats", 64'(q_b.size() >= 10), 64'd1);
    for (int k = 0; k < 10; k++) check_val("fair_din", 64'(q_b[k]), 64'(exp_fair[k]));
    check_val("fair_bubble", 64'(t_b[2] - t_b[1]), 64'd2);

    // backpressure after beat 2 for 5 cycles
    q_a.delete();
    t_a.delete();
    n_acc     = 0;
    req_valid = 4'b0100;
    run_until(2);
    prog_full = 1'b1;
    repeat (5) begin
      #1;
      check_val("bp_ready_low", 64'(req_ready), 64'd0);
      step();
    end
    prog_full = 1'b0;
    #1;
    check_val("bp_resume_ready", 64'(req_ready), 64'b0100);
    run_until(4);
    req_valid = 4'b0;
    repeat (3) step();
    check_val("bp_beats", 64'(q_a.size()), 64'd4);
    for (int k = 0; k < 4; k++) check_val("bp_din", 64'(q_a[k]), 64'(10'h230 + 10'(k)));
    check_val("bp_hold_gap", 64'(t_a[2] - t_a[1]), 64'd6);

    // reset during beat 2 of a burst
    q_a.delete();
    t_a.delete();
    n_acc     = 0;
    req_valid = 4'b0010;
    run_until(1);
    rst = 1'b0;
    step();
    check_val("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check_val("mid_rst_din", 64'(din), 64'd0);
    check_val("mid_rst_ready", 64'(req_ready), 64'd0);
    rst       = 1'b1;
    req_valid = 4'hF;
    step();
    #1;
    check_val("mid_rst_next_grant", 64'(req_ready), 64'b0001);
    req_valid = 4'b0;
    repeat (3) step();
    check_val("mid_rst_no_stray", 64'(q_a.size()), 64'd1);
    check_val("mid_rst_first_beat", 64'(q_a[0]), 64'h128);

    // early release from requester 2
    q_a.delete();
    t_a.delete();
    n_acc     = 0;
    req_valid = 4'b0100;
    run_until(1);
    req_valid = 4'b1001;
    #1;
    check_val("er_hold_ready", 64'(req_ready), 64'b0100);
    step();
    #1;
    check_val("er_bubble", 64'(req_ready), 64'd0);
    step();
    #1;
    check_val("er_next_grant", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'b0;
    repeat (3) step();
    check_val("er_beats", 64'(q_a.size()), 64'd2);
    check_val("er_din0", 64'(q_a[0]), 64'h234);
    check_val("er_din1", 64'(q_a[1]), 64'h340);

    // statistics: 10 beats from requester 3 after a fresh reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    q_a.delete();
    t_a.delete();
    n_acc     = 0;
    req_valid = 4'b1000;
    run_until(10);
    req_valid = 4'b0;
    repeat (3) step();
    check_val("st_beats", 64'(q_a.size()), 64'd10);
    check_val("st_last_din", 64'(q_a[9]), 64'h34A);
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_WR_ARB_STATS_EN
      check_val($sformatf("stat_cnt%0d", i), 64'(stat_cnt[i*32 +: 32]), (i == 3) ? 64'd10 : 64'd0);
`else
      check_val($sformatf("stat_cnt%0d", i), 64'(stat_cnt[i*32 +: 32]), 64'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width per requester.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..256).
REQ-004 SHALL have ports: clk  in  1  system clock; rst  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have ports: req_valid  in  NREQ  per-requester beat valid; req_data  in  NREQ*WIDTH  packed payload, requester i at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port req_ready  out  NREQ  per-requester beat accept.
REQ-007 SHALL have ports: wr_en  out  1  FIFO write strobe; din  out  WIDTH+IDW  FIFO write word, source ID in MSBs, payload in LSBs; prog_full  in  1  FIFO programmable-full backpressure.
REQ-008 SHALL have port stat_cnt  out  NREQ*32  per-requester accepted-beat counters.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and BURST (one requester granted).
REQ-010 In IDLE, if any req_valid is set, SHALL pick a requester round-robin starting at rr_ptr and enter BURST next cycle with that grant; if none is set, SHALL stay in IDLE.
REQ-011 req_ready[i] SHALL be combinational: state==BURST and grant==i and !prog_full; all other bits 0.
REQ-012 A beat is accepted when req_valid[i] and req_ready[i] are both high.
REQ-013 On an accepted beat, SHALL assert wr_en for exactly one cycle, the next cycle, with din = {i, req_data[i]} (registered, 1-cycle latency).
REQ-014 wr_en SHALL be 0 in any cycle not following an accept; din holds its last value when wr_en=0.
REQ-015 SHALL keep a burst counter, cleared on BURST entry and incremented per accept.
REQ-016 SHALL leave BURST for IDLE when the accept takes the counter to MAX_BURST, or when req_valid[grant] is low while prog_full is low.
REQ-017 On leaving BURST, SHALL set rr_ptr = (grant+1) mod NREQ.
REQ-018 While prog_full is high in BURST: SHALL hold the grant and counter, accept no beats, and not terminate on valid-low.
REQ-019 prog_full rising in the same cycle as a would-be accept SHALL block that accept; no beat is lost or duplicated.
REQ-020 Every IDLE visit SHALL cost one bubble cycle; peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
REQ-021 IDW SHALL equal max(1, clog2(NREQ)).

Reset
REQ-022 With rst low at a clk edge, SHALL set: state=IDLE, rr_ptr=0, burst counter=0, grant=0, wr_en=0, din=0, stat_cnt=0.
REQ-023 req_ready SHALL be 0 during reset and in the first cycle after reset.
REQ-024 Reset mid-burst SHALL abandon the burst; a pending wr_en for a beat accepted in the reset cycle SHALL NOT be issued.

Configuration
REQ-025 With macro FIFO_WR_ARB_STATS_EN defined, stat_cnt[i] SHALL increment by 1 on each accept from requester i and saturate at 32'hFFFF_FFFF.
REQ-026 Without FIFO_WR_ARB_STATS_EN, stat_cnt SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-027 Package fifo_wr_arb_pkg SHALL hold the FSM state enum and the IDW width-function.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_pick: inputs request vector and start pointer; outputs index and found flag.

Verification
REQ-029 Single requester: NREQ=4, MAX_BURST=4, req_valid=4'b0010 held for 8 beats -> bursts of 4 beats, 1 bubble, then 4 more beats; din MSBs=1, payloads in order.
REQ-030 Fairness: all four valid continuously, MAX_BURST=2 -> grant order 0,1,2,3,0; each burst exactly 2 beats.
REQ-031 Backpressure: prog_full high for 5 cycles mid-burst after beat 2 -> req_ready=0 for those 5 cycles, grant held, beats 3-4 resume, no loss or duplicate.
REQ-032 Early release: requester 2 drops valid after 1 beat with prog_full=0 -> return to IDLE, rr_ptr=3; next grant goes to 3 if valid.
REQ-033 Reset mid-burst: rst low for 1 cycle during beat 2 -> outputs at reset values, next grant from requester 0, no stray wr_en.
REQ-034 Stats: with FIFO_WR_ARB_STATS_EN, 10 beats from requester 3 -> stat_cnt[3]=10, others 0; without the macro, all 0.
